// File: rtl/axi_slv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_slv_mem_responder
// Purpose  : AXI4 slave end-point backed by an internal byte-addressed memory.
//            The write and read channels run independently. Each channel has
//            one burst in flight. INCR and FIXED bursts are supported. WRAP and
//            reserved burst types, and oversize beats, answer SLVERR. Accesses
//            that fall outside the memory answer DECERR.
// Ports    : aclk / reset         - clock, synchronous active-high reset
//            s_aw* / s_w* / s_b*  - write address, write data, write response
//            s_ar* / s_r*         - read address, read data
// Revision : 1.0  initial release
// ============================================================================
module axi_slv_mem_responder #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic                aclk,
  input  logic                reset,
  // write address
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  // write data
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  // write response
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  // read address
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic                s_arvalid,
  output logic                s_arready,
  // read data
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int LANE_BITS = $clog2(STRB_W);
  localparam int MEM_AW    = $clog2(MEM_BYTES);
  localparam int NWORDS    = MEM_BYTES / STRB_W;
  localparam int IDX_W     = MEM_AW - LANE_BITS;
  localparam int XW        = ADDR_W + 9;

  localparam logic [1:0] c_OKAY     = 2'b00;
  localparam logic [1:0] c_SLVERR   = 2'b10;
  localparam logic [1:0] c_DECERR   = 2'b11;
  localparam logic [1:0] c_FIXED    = 2'b00;
  localparam logic [1:0] c_INCR     = 2'b01;
  localparam logic [2:0] c_MAX_SIZE = 3'(LANE_BITS);

  typedef logic [XW-1:0]     ext_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LANE_BITS:0] lane_t;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_t;

  // --------------------------------------------------------------------------
  // Error class of a whole burst. It is evaluated once, at address accept.
  // The end address uses a wide datapath so that a top-of-space burst cannot
  // wrap around and appear to be in range.
  // --------------------------------------------------------------------------
  function automatic logic [1:0] f_addr_resp(input addr_t      addr,
                                             input logic [7:0] len,
                                             input logic [2:0] size,
                                             input logic [1:0] burst);
    ext_t v_start;
    ext_t v_span;
    ext_t v_last;
    v_start = ext_t'(addr);
    if (burst == c_FIXED) v_span = ext_t'(1) << size;
    else                  v_span = (ext_t'(len) + ext_t'(1)) << size;
    v_last = v_start + v_span - ext_t'(1);
    if ((v_start >= ext_t'(MEM_BYTES)) || (v_last >= ext_t'(MEM_BYTES)))
      return c_DECERR;
    if ((burst != c_FIXED) && (burst != c_INCR))
      return c_SLVERR;
    if (size > c_MAX_SIZE)
      return c_SLVERR;
    return c_OKAY;
  endfunction

  // The next beat address is aligned to the beat size. As a result, only the
  // first beat of an unaligned INCR burst is unaligned.
  function automatic addr_t f_next_addr(input addr_t      addr,
                                        input logic [2:0] size,
                                        input logic [1:0] burst);
    addr_t v_step;
    v_step = addr_t'(1) << size;
    if (burst == c_FIXED) return addr;
    return (addr & ~(v_step - addr_t'(1))) + v_step;
  endfunction

  // --------------------------------------------------------------------------
  // Storage. This is a word array and it has no reset, so its contents
  // survive a reset.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [NWORDS];

  // --------------------------------------------------------------------------
  // Write channel state
  // --------------------------------------------------------------------------
  wstate_t           r_wstate;
  logic              r_awready;
  logic              r_wready;
  logic              r_bvalid;
  logic [ID_W-1:0]   r_bid;
  logic [1:0]        r_bresp;
  logic [ID_W-1:0]   r_wid;
  addr_t             r_waddr;
  logic [7:0]        r_wlen;
  logic [2:0]        r_wsize;
  logic [1:0]        r_wburst;
  logic [7:0]        r_wcnt;
  logic [1:0]        r_waresp;
  logic              r_wlast_err;

  logic [IDX_W-1:0]  w_widx;
  lane_t             w_woff;
  lane_t             w_wend;
  logic [STRB_W-1:0] w_wlane_en;
  logic              w_wbeat;
  logic              w_wmem_we;

  assign w_widx = r_waddr[MEM_AW-1:LANE_BITS];

  // Only lanes inside the current beat's size-aligned window are written.
  // The window starts at the address offset, so an unaligned first beat
  // drops the lanes below the start.
  always_comb begin
    w_wlane_en = '0;
    w_woff     = {1'b0, r_waddr[LANE_BITS-1:0]};
    w_wend     = ((w_woff >> r_wsize) << r_wsize) + (lane_t'(1) << r_wsize);
    for (int k = 0; k < STRB_W; k++) begin
      w_wlane_en[k] = s_wstrb[k] && (lane_t'(k) >= w_woff) && (lane_t'(k) < w_wend);
    end
  end

  assign w_wbeat   = (r_wstate == W_DATA) && s_wvalid && r_wready;
  // Bursts that fail the address check leave memory untouched. A WLAST
  // protocol error still writes its beats.
  assign w_wmem_we = w_wbeat && (r_waresp == c_OKAY) && !reset;

  always_ff @(posedge aclk) begin
    if (w_wmem_we) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (w_wlane_en[k]) r_mem[w_widx][k*8 +: 8] <= s_wdata[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_wstate    <= W_IDLE;
      r_awready   <= 1'b1;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bid       <= '0;
      r_bresp     <= '0;
      r_wid       <= '0;
      r_waddr     <= '0;
      r_wlen      <= '0;
      r_wsize     <= '0;
      r_wburst    <= '0;
      r_wcnt      <= '0;
      r_waresp    <= '0;
      r_wlast_err <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (s_awvalid) begin
            r_wid       <= s_awid;
            r_waddr     <= s_awaddr;
            r_wlen      <= s_awlen;
            r_wsize     <= s_awsize;
            r_wburst    <= s_awburst;
            r_waresp    <= f_addr_resp(s_awaddr, s_awlen, s_awsize, s_awburst);
            r_wcnt      <= '0;
            r_wlast_err <= 1'b0;
            r_awready   <= 1'b0;
            r_wready    <= 1'b1;
            r_wstate    <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_wvalid) begin
            r_waddr <= f_next_addr(r_waddr, r_wsize, r_wburst);
            r_wcnt  <= r_wcnt + 8'd1;
            // The beat count alone ends the burst. WLAST only flags errors.
            if (r_wcnt == r_wlen) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_wid;
              if (r_waresp != c_OKAY)             r_bresp <= r_waresp;
              else if (r_wlast_err || !s_wlast)   r_bresp <= c_SLVERR;
              else                                r_bresp <= c_OKAY;
              r_wstate <= W_RESP;
            end else if (s_wlast) begin
              r_wlast_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  assign s_awready = r_awready;
  assign s_wready  = r_wready;
  assign s_bvalid  = r_bvalid;
  assign s_bid     = r_bid;
  assign s_bresp   = r_bresp;

  // --------------------------------------------------------------------------
  // Read channel state
  // --------------------------------------------------------------------------
  rstate_t           r_rstate;
  logic              r_arready;
  logic              r_rvalid;
  logic              r_rlast;
  logic [ID_W-1:0]   r_rid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic [ID_W-1:0]   r_arid_l;
  addr_t             r_raddr;
  logic [7:0]        r_rlen;
  logic [2:0]        r_rsize;
  logic [1:0]        r_rburst;
  logic [7:0]        r_rcnt;
  logic [1:0]        r_raresp;

  logic [IDX_W-1:0]  w_ridx;

  assign w_ridx = r_raddr[MEM_AW-1:LANE_BITS];

  // R_FETCH is the synchronous memory read cycle. A write to the same word
  // on the same edge lands after this sample, so the read sees the old data.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_arid_l  <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rsize   <= '0;
      r_rburst  <= '0;
      r_rcnt    <= '0;
      r_raresp  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (s_arvalid) begin
            r_arid_l  <= s_arid;
            r_raddr   <= s_araddr;
            r_rlen    <= s_arlen;
            r_rsize   <= s_arsize;
            r_rburst  <= s_arburst;
            r_raresp  <= f_addr_resp(s_araddr, s_arlen, s_arsize, s_arburst);
            r_rcnt    <= '0;
            r_arready <= 1'b0;
            r_rstate  <= R_FETCH;
          end
        end
        R_FETCH: begin
          r_rdata  <= (r_raresp == c_OKAY) ? r_mem[w_ridx] : '0;
          r_rresp  <= r_raresp;
          r_rid    <= r_arid_l;
          r_rlast  <= (r_rcnt == r_rlen);
          r_rvalid <= 1'b1;
          r_rstate <= R_DATA;
        end
        R_DATA: begin
          if (s_rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (r_rlast) begin
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_raddr  <= f_next_addr(r_raddr, r_rsize, r_rburst);
              r_rcnt   <= r_rcnt + 8'd1;
              r_rstate <= R_FETCH;
            end
          end
        end
        default: begin
          r_rstate <= R_IDLE;
        end
      endcase
    end
  end

  assign s_arready = r_arready;
  assign s_rvalid  = r_rvalid;
  assign s_rlast   = r_rlast;
  assign s_rid     = r_rid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;

endmodule
`default_nettype wire

// File: doc/axi_slv_mem_responder.md
Name: axi_slv_mem_responder

Overview:
- Synthesizable AXI4 slave with an internal byte-addressed memory.
- Answers write and read bursts from an AXI master, e.g. the AXI VIP in master mode or the iDMA engine in chip-level benches.
- Provides an RTL end-point in place of the VIP memory model, so the monitors and scoreboards see a real responder.
- Write and read channels are independent; each channel has one outstanding burst.

Parameters:
ID_W, 4, width of AWID/BID/ARID/RID
ADDR_W, 32, address width
DATA_W, 32, data width; must be 32 or 64
MEM_BYTES, 4096, memory size; power of 2; valid addresses are 0..MEM_BYTES-1

Ports:
aclk  in  1  clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
s_awid/s_awaddr/s_awlen/s_awsize/s_awburst  in  ID_W/ADDR_W/8/3/2  write address
s_awvalid in 1; s_awready out 1  AW handshake
s_wdata/s_wstrb/s_wlast  in  DATA_W/DATA_W/8/1  write data
s_wvalid in 1; s_wready out 1  W handshake
s_bid/s_bresp  out  ID_W/2  write response
s_bvalid out 1; s_bready in 1  B handshake
s_arid/s_araddr/s_arlen/s_arsize/s_arburst  in  ID_W/ADDR_W/8/3/2  read address
s_arvalid in 1; s_arready out 1  AR handshake
s_rid/s_rdata/s_rresp/s_rlast  out  ID_W/DATA_W/2/1  read data
s_rvalid out 1; s_rready in 1  R handshake

Behaviour:
- Reset (synchronous, active-high):
  - Both FSMs go to IDLE.
  - s_awready=1, s_arready=1; s_wready, s_bvalid, s_rvalid, s_rlast = 0.
  - s_bid, s_bresp, s_rid, s_rdata, s_rresp = 0.
  - Memory contents are NOT cleared.
  - Reset mid-burst abandons the burst; no response is issued.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/size/burst, compute the error class, go to W_DATA. awready=0 outside W_IDLE.
  - W_DATA: wready=1. Each W handshake is one beat.
  - W_DATA, no error: bytes with wstrb=1 are written at the current address, byte lane = addr mod (DATA_W/8).
  - Beat counter runs 0..len. On beat len, go to W_RESP.
  - WLAST does not terminate the burst. WLAST asserted early, or missing on beat len, sets SLVERR, but all len+1 beats are still consumed and written.
  - W_RESP: bvalid=1, bid=latched id. Hold until bready, then go to W_IDLE. Earliest B is the cycle after the last W handshake.
- Read FSM: R_IDLE -> R_FETCH -> R_DATA -> (R_FETCH | R_IDLE).
  - R_IDLE: arready=1. On AR handshake, latch fields, go to R_FETCH.
  - R_FETCH: one synchronous memory read cycle, then R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rlast=(beat==len). rdata/rresp are stable until the rready handshake.
  - After the handshake: go to R_FETCH with the next address, or to R_IDLE if last.
  - Throughput is 1 beat per 2 cycles. First RVALID is 2 cycles after the AR handshake.
- Address update per beat:
  - INCR: addr += 1<<size; narrow beats use the lane of the current address.
  - FIXED: addr is unchanged.
- Error classes (computed at address accept; one resp value covers the whole burst):
  - burst==WRAP or burst==2'b11: SLVERR.
  - size > log2(DATA_W/8): SLVERR.
  - Start or final byte address (INCR: start + ((len+1)<<size) - 1) >= MEM_BYTES, computed ADDR_W+9 bits wide without wrap: DECERR.
  - Precedence: DECERR over SLVERR.
  - Error bursts perform no memory writes. Error reads return rdata=0. Beat count and handshakes are unchanged.
- Simultaneous write and read to the same byte in the same cycle: the read returns the old data (read-before-write).
- AW and AR may be accepted in the same cycle; the channels never block each other.
- Unaligned INCR start: only the first beat is unaligned. Lanes below the start offset are ignored on write and undefined on read.

Test Plan:
- Reset, then AW {id=3, addr=0x100, len=3, size=2, INCR} with W data 0x11111111..0x44444444, strb=F -> 4 W handshakes, then B id=3 OKAY. AR same burst -> rdata 0x11111111..0x44444444, rlast on beat 3 only, rresp OKAY.
- Write 0xAABBCCDD at 0x200, then write strb=0x6 with data 0x00EE9900 -> read 0x200 returns 0xAAEE99DD.
- AW addr=0xFFC, len=1, size=2 (DATA_W=32, MEM_BYTES=4096) -> 2 W beats accepted, BRESP=DECERR, memory at 0xFFC unchanged. AR same -> 2 beats, rdata=0, rresp=DECERR.
- AW burst=WRAP, len=3 -> BRESP=SLVERR, no writes. W with wlast on beat 1 of len=3 -> 4 beats written, BRESP=SLVERR.
- Backpressure: bready=0 for 5 cycles -> bvalid, bid, bresp held stable, awready=0 until handshake. Random rready -> rdata/rlast stable while rvalid & !rready.
- Concurrent AW+AR in one cycle to disjoint regions -> both complete with correct data. Assert reset mid-read at beat 1 of len=7 -> rvalid=0 next cycle, arready=1, memory intact on re-read.
